pf_stride_gen: RTL and testbench
================================

PF_STRIDE_GEN -- requirements
Module: pf_stride_gen

Interface
REQ-001 SHALL have parameter DEGREE, default 4'd2, meaning the prefetch degree copied into every issued op.
REQ-002 SHALL have parameter CONF_THRESH, default 2, meaning the minimum confidence (after update) required to issue.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port obs_valid  input  1  load-miss observation valid.
REQ-006 SHALL have port obs_retry  output  1  observation back-pressure.
REQ-007 SHALL have port obs_pc  input  16  PC of observed load.
REQ-008 SHALL have port obs_addr  input  48  byte address of observed load.
REQ-009 SHALL have port flush  input  1  invalidate all training entries.
REQ-010 SHALL have port pfgtopfe_op_valid  output  1  prefetch op valid toward pfengine.
REQ-011 SHALL have port pfgtopfe_op_retry  input  1  pfengine back-pressure.
REQ-012 SHALL have port pfgtopfe_op_laddr  output  42  first line address to prefetch.
REQ-013 SHALL have port pfgtopfe_op_stride  output  12  signed stride, in lines.
REQ-014 SHALL have port pfgtopfe_op_degree  output  4  number of lines to prefetch.
REQ-015 SHALL have ports stat_trains and stat_issues  output  16 each  saturating event counters.

Function
REQ-016 SHALL accept an observation in a cycle with obs_valid=1 and obs_retry=0; valid/retry handshake, no accepted observation lost.
REQ-017 SHALL drive obs_retry = pfgtopfe_op_valid & pfgtopfe_op_retry (combinational; output register stalled).
REQ-018 SHALL hold a 16-entry direct-mapped table: index obs_pc[5:2], tag obs_pc[15:6]; entry = {valid, tag[9:0], last[41:0], stride[11:0] signed, conf[1:0]}.
REQ-019 SHALL compute line = obs_addr[47:6] and delta = line - last (42-bit two's complement).
REQ-020 Miss (entry invalid or tag mismatch): SHALL write valid=1, tag, last=line, stride=0, conf=0; no issue.
REQ-021 Hit with delta==0: SHALL leave entry unchanged; no issue.
REQ-022 Hit with delta in [-2048,2047] and delta[11:0]==stride: SHALL set conf=min(conf+1,3) and last=line.
REQ-023 Hit otherwise: SHALL set stride=delta[11:0] if delta in range else 0, conf=0, last=line; no issue.
REQ-024 SHALL issue only under REQ-022 when new conf >= CONF_THRESH and stride != 0: laddr = line + sign-extended stride (mod 2^42), stride, degree=DEGREE.
REQ-025 Table read-modify-write SHALL complete in the accept cycle; a same-index observation in the next cycle SHALL see the updated entry.
REQ-026 Output register SHALL load in the cycle after accept (latency 1), only when it is empty or drained (valid & ~retry) that cycle; guaranteed by REQ-017.
REQ-027 While pfgtopfe_op_valid=1 and pfgtopfe_op_retry=1, all pfgtopfe_op_* outputs SHALL hold stable.
REQ-028 stat_trains SHALL increment on every accepted observation that is not flushed; stat_issues on every issue; both saturate at 16'hFFFF.
REQ-029 flush SHALL clear all entry valid bits at the clock edge; flush with a simultaneous accepted observation: flush wins, observation has no table effect, no issue, not counted.
REQ-030 flush SHALL NOT affect the output register or counters.

Reset
REQ-031 On reset SHALL clear all table valid bits, pfgtopfe_op_valid=0, laddr=0, stride=0, degree=0, stat_trains=0, stat_issues=0; obs_retry therefore 0.
REQ-032 Reset asserted while an op is pending/stalled SHALL discard it; no op emitted after reset deasserts until a new issue.

Verification
REQ-033 pc=0x0040, addrs 0x1000,0x1040,0x1080,0x10C0 on consecutive cycles, retry=0 -> single issue after 4th accept, next cycle: laddr=0x44, stride=1, degree=2; stat_trains=4, stat_issues=1.
REQ-034 Same stream with stride -3 lines from 0x10000 -> issue laddr=0x3F4 (line 0x3F7-3), stride=12'hFFD.
REQ-035 Hold pfgtopfe_op_retry=1 during trained stream -> obs_retry=1 while op valid, op stable, no observation dropped; release -> remaining issues follow in order.
REQ-036 Alias pc 0x0040 vs 0x0080 (same index, different tag) interleaved -> every access reallocates, zero issues.
REQ-037 Delta 4096 lines on trained entry -> stride=0, conf=0, no issue; flush coincident with 4th observation -> no issue, stat_trains=3.
REQ-038 Reset mid-stall with op pending -> pfgtopfe_op_valid=0 next cycle, counters 0, first post-reset observation treated as miss.

Source files
------------

// File: rtl/pf_stride_gen.sv
// Per-PC stride prefetch generator: a 16-entry direct-mapped training table feeds
// a single-entry output register toward the prefetch engine.
module pf_stride_gen #(
  parameter logic [3:0] DEGREE      = 4'd2,
  parameter int         CONF_THRESH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        obs_valid,
  output logic        obs_retry,
  input  logic [15:0] obs_pc,
  input  logic [47:0] obs_addr,
  input  logic        flush,
  output logic        pfgtopfe_op_valid,
  input  logic        pfgtopfe_op_retry,
  output logic [41:0] pfgtopfe_op_laddr,
  output logic [11:0] pfgtopfe_op_stride,
  output logic [3:0]  pfgtopfe_op_degree,
  output logic [15:0] stat_trains,
  output logic [15:0] stat_issues
);

  // Handshakes: a transfer happens on a posedge where valid=1 and retry=0.
  // Both sides hold valid and payload stable while retry=1.

  logic [15:0] tbl_valid_q, tbl_valid_d;
  logic [9:0]  tbl_tag_q    [16];
  logic [41:0] tbl_last_q   [16];
  logic [11:0] tbl_stride_q [16];
  logic [1:0]  tbl_conf_q   [16];

  logic        op_valid_q, op_valid_d;
  logic [41:0] op_laddr_q, op_laddr_d;
  logic [11:0] op_stride_q, op_stride_d;
  logic [3:0]  op_degree_q, op_degree_d;
  logic [15:0] trains_q, trains_d;
  logic [15:0] issues_q, issues_d;

  logic [3:0]  idx;
  logic [9:0]  tag;
  logic [41:0] line;
  logic [41:0] delta;
  logic        in_range;
  logic        accept;
  logic        train;
  logic        hit;
  logic        issue;
  logic        wr_en;
  logic [41:0] wr_last;
  logic [11:0] wr_stride;
  logic [1:0]  wr_conf;
  logic        unused_bits;

  assign obs_retry   = op_valid_q & pfgtopfe_op_retry;
  assign unused_bits = ^{obs_pc[1:0], obs_addr[5:0]};

  always_comb begin
    idx      = obs_pc[5:2];
    tag      = obs_pc[15:6];
    line     = obs_addr[47:6];
    delta    = line - tbl_last_q[idx];
    in_range = (&delta[41:11]) | ~(|delta[41:11]);
    accept   = obs_valid & ~obs_retry;
    train    = accept & ~flush;
    hit      = tbl_valid_q[idx] && (tbl_tag_q[idx] == tag);

    wr_en     = 1'b0;
    wr_last   = line;
    wr_stride = tbl_stride_q[idx];
    wr_conf   = tbl_conf_q[idx];
    issue     = 1'b0;

    if (train) begin
      if (!hit) begin
        wr_en     = 1'b1;
        wr_stride = '0;
        wr_conf   = '0;
      end else if (delta == '0) begin
        wr_en = 1'b0;
      end else if (in_range && (delta[11:0] == tbl_stride_q[idx])) begin
        wr_en   = 1'b1;
        wr_conf = (tbl_conf_q[idx] == 2'd3) ? 2'd3 : tbl_conf_q[idx] + 2'd1;
        issue   = (int'({30'd0, wr_conf}) >= CONF_THRESH) && (tbl_stride_q[idx] != '0);
      end else begin
        wr_en     = 1'b1;
        wr_stride = in_range ? delta[11:0] : 12'd0;
        wr_conf   = '0;
      end
    end

    // Flush beats any same-cycle allocation: every entry ends up invalid.
    tbl_valid_d = tbl_valid_q;
    if (flush)      tbl_valid_d = '0;
    else if (wr_en) tbl_valid_d[idx] = 1'b1;

    // obs_retry keeps accepts out of stalled cycles, so a load here never overwrites a held op.
    op_valid_d  = op_valid_q & pfgtopfe_op_retry;
    op_laddr_d  = op_laddr_q;
    op_stride_d = op_stride_q;
    op_degree_d = op_degree_q;
    if (issue) begin
      op_valid_d  = 1'b1;
      op_laddr_d  = line + {{30{tbl_stride_q[idx][11]}}, tbl_stride_q[idx]};
      op_stride_d = tbl_stride_q[idx];
      op_degree_d = DEGREE;
    end

    trains_d = (train && trains_q != 16'hFFFF) ? trains_q + 16'd1 : trains_q;
    issues_d = (issue && issues_q != 16'hFFFF) ? issues_q + 16'd1 : issues_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_valid_q <= '0;
      op_valid_q  <= 1'b0;
      op_laddr_q  <= '0;
      op_stride_q <= '0;
      op_degree_q <= '0;
      trains_q    <= '0;
      issues_q    <= '0;
    end else begin
      tbl_valid_q <= tbl_valid_d;
      op_valid_q  <= op_valid_d;
      op_laddr_q  <= op_laddr_d;
      op_stride_q <= op_stride_d;
      op_degree_q <= op_degree_d;
      trains_q    <= trains_d;
      issues_q    <= issues_d;
    end
  end

  // Entry payload needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      tbl_tag_q[idx]    <= tag;
      tbl_last_q[idx]   <= wr_last;
      tbl_stride_q[idx] <= wr_stride;
      tbl_conf_q[idx]   <= wr_conf;
    end
  end

  assign pfgtopfe_op_valid  = op_valid_q;
  assign pfgtopfe_op_laddr  = op_laddr_q;
  assign pfgtopfe_op_stride = op_stride_q;
  assign pfgtopfe_op_degree = op_degree_q;
  assign stat_trains        = trains_q;
  assign stat_issues        = issues_q;

endmodule

// File: tb/tb_pf_stride_gen.sv
// Directed bench for pf_stride_gen: vector table for training streams, hand-written
// sequences for flush, back-pressure and reset-under-stall.
module tb_pf_stride_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        obs_valid = 1'b0;
  logic        obs_retry;
  logic [15:0] obs_pc = '0;
  logic [47:0] obs_addr = '0;
  logic        flush = 1'b0;
  logic        op_valid;
  logic        op_retry = 1'b0;
  logic [41:0] op_laddr;
  logic [11:0] op_stride;
  logic [3:0]  op_degree;
  logic [15:0] stat_trains;
  logic [15:0] stat_issues;

  int checks = 0;
  int errors = 0;

  pf_stride_gen dut (
    .clk                (clk),
    .reset              (reset),
    .obs_valid          (obs_valid),
    .obs_retry          (obs_retry),
    .obs_pc             (obs_pc),
    .obs_addr           (obs_addr),
    .flush              (flush),
    .pfgtopfe_op_valid  (op_valid),
    .pfgtopfe_op_retry  (op_retry),
    .pfgtopfe_op_laddr  (op_laddr),
    .pfgtopfe_op_stride (op_stride),
    .pfgtopfe_op_degree (op_degree),
    .stat_trains        (stat_trains),
    .stat_issues        (stat_issues)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [15:0] pc;
    logic [47:0] addr;
    logic        ev;
    logic [41:0] el;
    logic [11:0] es;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic obs(input logic [15:0] pc, input logic [47:0] addr);
    obs_valid = 1'b1;
    obs_pc    = pc;
    obs_addr  = addr;
    cyc();
    obs_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [15:0] pc, input logic [47:0] addr,
                              input logic ev, input logic [41:0] el, input logic [11:0] es);
    vec_t v;
    v.ov = 1'b1; v.pc = pc; v.addr = addr; v.ev = ev; v.el = el; v.es = es;
    return v;
  endfunction

  initial begin
    // +1 line stream: issue on 4th access
    vecs[0]  = mk(16'h0040, 48'h1000,  0, 0, 0);
    vecs[1]  = mk(16'h0040, 48'h1040,  0, 0, 0);
    vecs[2]  = mk(16'h0040, 48'h1080,  0, 0, 0);
    vecs[3]  = mk(16'h0040, 48'h10C0,  1, 42'h44, 12'h001);
    // -3 line stream, then saturated conf, then delta 0 and continuation
    vecs[4]  = mk(16'h0044, 48'h10000, 0, 0, 0);
    vecs[5]  = mk(16'h0044, 48'hFF40,  0, 0, 0);
    vecs[6]  = mk(16'h0044, 48'hFE80,  0, 0, 0);
    vecs[7]  = mk(16'h0044, 48'hFDC0,  1, 42'h3F4, 12'hFFD);
    vecs[8]  = mk(16'h0044, 48'hFD00,  1, 42'h3F1, 12'hFFD);
    vecs[9]  = mk(16'h0044, 48'hFD00,  0, 0, 0);
    vecs[10] = mk(16'h0044, 48'hFC40,  1, 42'h3EE, 12'hFFD);
    // aliasing PCs on index 2
    vecs[11] = mk(16'h0048, 48'h2000,  0, 0, 0);
    vecs[12] = mk(16'h0088, 48'h3000,  0, 0, 0);
    vecs[13] = mk(16'h0048, 48'h2040,  0, 0, 0);
    vecs[14] = mk(16'h0088, 48'h3040,  0, 0, 0);
    vecs[15] = mk(16'h0048, 48'h2080,  0, 0, 0);
    vecs[16] = mk(16'h0088, 48'h3080,  0, 0, 0);
    vecs[17] = mk(16'h0048, 48'h20C0,  0, 0, 0);
    vecs[18] = mk(16'h0088, 48'h30C0,  0, 0, 0);
    // train, then a 4096-line jump resets stride/conf, then retrain
    vecs[19] = mk(16'h004C, 48'h4000,  0, 0, 0);
    vecs[20] = mk(16'h004C, 48'h4040,  0, 0, 0);
    vecs[21] = mk(16'h004C, 48'h4080,  0, 0, 0);
    vecs[22] = mk(16'h004C, 48'h40C0,  1, 42'h104, 12'h001);
    vecs[23] = mk(16'h004C, 48'h440C0, 0, 0, 0);
    vecs[24] = mk(16'h004C, 48'h44100, 0, 0, 0);
    vecs[25] = mk(16'h004C, 48'h44140, 0, 0, 0);
    vecs[26] = mk(16'h004C, 48'h44180, 1, 42'h1107, 12'h001);
    vecs[27] = mk(16'h004C, 48'h44180, 0, 0, 0);

    cyc(); cyc();
    chk("rst_op_valid", {47'd0, op_valid}, 48'd0);
    chk("rst_laddr", {6'd0, op_laddr}, 48'd0);
    chk("rst_stride", {36'd0, op_stride}, 48'd0);
    chk("rst_degree", {44'd0, op_degree}, 48'd0);
    chk("rst_trains", {32'd0, stat_trains}, 48'd0);
    chk("rst_issues", {32'd0, stat_issues}, 48'd0);
    chk("rst_obs_retry", {47'd0, obs_retry}, 48'd0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < NV; i++) begin
      obs_valid = vecs[i].ov;
      obs_pc    = vecs[i].pc;
      obs_addr  = vecs[i].addr;
      cyc();
      chk($sformatf("vec%0d_valid", i), {47'd0, op_valid}, {47'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_laddr", i), {6'd0, op_laddr}, {6'd0, vecs[i].el});
        chk($sformatf("vec%0d_stride", i), {36'd0, op_stride}, {36'd0, vecs[i].es});
        chk($sformatf("vec%0d_degree", i), {44'd0, op_degree}, 48'd2);
      end
    end
    obs_valid = 1'b0;
    cyc();
    chk("tbl_trains", {32'd0, stat_trains}, 48'd28);
    chk("tbl_issues", {32'd0, stat_issues}, 48'd6);

    // flush coincident with the would-be issuing observation
    obs(16'h0050, 48'h5000);
    obs(16'h0050, 48'h5040);
    obs(16'h0050, 48'h5080);
    flush = 1'b1;
    obs(16'h0050, 48'h50C0);
    flush = 1'b0;
    chk("flush_no_issue", {47'd0, op_valid}, 48'd0);
    chk("flush_trains", {32'd0, stat_trains}, 48'd31);
    obs(16'h0050, 48'h50C0);
    chk("flush_cleared", {47'd0, op_valid}, 48'd0);
    chk("flush_trains2", {32'd0, stat_trains}, 48'd32);

    // back-pressure: op held, observation retried, then released
    op_retry = 1'b1;
    obs(16'h0054, 48'h6000);
    obs(16'h0054, 48'h6040);
    obs(16'h0054, 48'h6080);
    obs(16'h0054, 48'h60C0);
    chk("stall_valid", {47'd0, op_valid}, 48'd1);
    chk("stall_laddr", {6'd0, op_laddr}, 48'h184);
    obs_valid = 1'b1;
    obs_pc    = 16'h0054;
    obs_addr  = 48'h6100;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_obs_retry", k), {47'd0, obs_retry}, 48'd1);
      cyc();
      chk($sformatf("stall%0d_valid", k), {47'd0, op_valid}, 48'd1);
      chk($sformatf("stall%0d_laddr", k), {6'd0, op_laddr}, 48'h184);
      chk($sformatf("stall%0d_stride", k), {36'd0, op_stride}, 48'h001);
      chk($sformatf("stall%0d_trains", k), {32'd0, stat_trains}, 48'd36);
    end
    op_retry = 1'b0;
    #1;
    chk("release_obs_retry", {47'd0, obs_retry}, 48'd0);
    cyc();
    chk("release1_valid", {47'd0, op_valid}, 48'd1);
    chk("release1_laddr", {6'd0, op_laddr}, 48'h185);
    obs(16'h0054, 48'h6140);
    chk("release2_valid", {47'd0, op_valid}, 48'd1);
    chk("release2_laddr", {6'd0, op_laddr}, 48'h186);
    cyc();
    chk("release_drained", {47'd0, op_valid}, 48'd0);
    chk("release_trains", {32'd0, stat_trains}, 48'd38);
    chk("release_issues", {32'd0, stat_issues}, 48'd9);

    // reset while an op is stalled
    op_retry = 1'b1;
    obs(16'h0058, 48'h7000);
    obs(16'h0058, 48'h7040);
    obs(16'h0058, 48'h7080);
    obs(16'h0058, 48'h70C0);
    chk("pre_rst_valid", {47'd0, op_valid}, 48'd1);
    reset = 1'b1;
    cyc();
    chk("midrst_valid", {47'd0, op_valid}, 48'd0);
    chk("midrst_trains", {32'd0, stat_trains}, 48'd0);
    chk("midrst_issues", {32'd0, stat_issues}, 48'd0);
    chk("midrst_obs_retry", {47'd0, obs_retry}, 48'd0);
    reset = 1'b0;
    cyc();
    chk("postrst_valid", {47'd0, op_valid}, 48'd0);
    obs(16'h0058, 48'h7100);
    chk("postrst_miss1", {47'd0, op_valid}, 48'd0);
    obs(16'h0058, 48'h7140);
    chk("postrst_miss2", {47'd0, op_valid}, 48'd0);
    obs(16'h0058, 48'h7180);
    chk("postrst_miss3", {47'd0, op_valid}, 48'd0);
    chk("postrst_trains", {32'd0, stat_trains}, 48'd3);
    chk("postrst_issues", {32'd0, stat_issues}, 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
